pll_lock_reset_seq: RTL and testbench



---
 rtl/pll_lock_reset_seq.sv | 113 +++++++++++
 tb/tb_pll_lock_reset_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// PLL reset sequencer on the free-running refclk: pulses pll_rst, qualifies lock, releases sys_rst.
// Optional build macro PLL_LOCK_RESEQ_AUTO_RECOVER_EN: lock loss in RUN re-pulses the PLL reset.
module pll_lock_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] loss_cnt
);
  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  logic             meta_q, lk_q;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             timeout_hit, loss_hit;

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    case (state_q)
      S_PLL_RST:   if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over the retry.
        if (lk_q) state_d = S_SETTLE;
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_PLL_RST;
          timeout_hit = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lk_q) state_d = S_WAIT_LOCK;
        else if (cnt_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lk_q) begin
          loss_hit = 1'b1;
`ifdef PLL_LOCK_RESEQ_AUTO_RECOVER_EN
          state_d  = S_PLL_RST;
`else
          state_d  = S_WAIT_LOCK;
`endif
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    // Outputs are decoded from the next state so each is a plain flop output.
    cnt_d         = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    pll_rst_d     = (state_d == S_PLL_RST);
    sys_rst_d     = (state_d != S_RUN);
    ready_d       = (state_d == S_RUN) && (state_q != S_RUN);
    timeout_cnt_d = (timeout_hit && !(&timeout_cnt_q)) ? timeout_cnt_q + 1'b1 : timeout_cnt_q;
    loss_cnt_d    = (loss_hit && !(&loss_cnt_q)) ? loss_cnt_q + 1'b1 : loss_cnt_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      meta_q        <= 1'b0;
      lk_q          <= 1'b0;
      state_q       <= S_PLL_RST;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      timeout_cnt_q <= '0;
      loss_cnt_q    <= '0;
    end else begin
      meta_q        <= pll_locked;
      lk_q          <= meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      timeout_cnt_q <= timeout_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign timeout_cnt = timeout_cnt_q;
  assign loss_cnt    = loss_cnt_q;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios plus random lock chatter against a phase/timer model.
module tb_pll_lock_reset_seq;
  localparam int R  = 4;
  localparam int T  = 20;
  localparam int S  = 8;
  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;
`ifdef PLL_LOCK_RESEQ_AUTO_RECOVER_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, pll_locked;
  logic          pll_rst, sys_rst, ready;
  logic [1:0]    state;
  logic [CW-1:0] timeout_cnt, loss_cnt;

  int checks = 0;
  int fails  = 0;

  pll_lock_reset_seq #(.PLL_RST_CYCLES(R), .LOCK_TIMEOUT(T), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .refclk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .ready(ready), .state(state), .timeout_cnt(timeout_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a phase (0..3), time spent in it, and a 2-deep history of sampled lock.
  int m_ph, m_t, m_tc, m_lc;
  bit m_s1, m_s2, m_rdy, m_valid = 1'b0;

  task automatic model_step();
    bit lk;
    int nxt;
    lk = m_s2;
    if (rst) begin
      m_ph = 0; m_t = 0; m_tc = 0; m_lc = 0; m_s1 = 0; m_s2 = 0; m_rdy = 0; m_valid = 1;
      return;
    end
    m_s2 = m_s1;
    m_s1 = pll_locked;
    nxt  = m_ph;
    case (m_ph)
      0: if (m_t == R - 1) nxt = 1;
      1: if (lk) nxt = 2;
         else if (m_t == T - 1) begin nxt = 0; if (m_tc < SAT) m_tc++; end
      2: if (!lk) nxt = 1;
         else if (m_t == S - 1) nxt = 3;
      default: if (!lk) begin nxt = AUTO ? 0 : 1; if (m_lc < SAT) m_lc++; end
    endcase
    m_rdy = (m_ph != 3) && (nxt == 3);
    m_t   = (nxt != m_ph) ? 0 : m_t + 1;
    m_ph  = nxt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("m_state", state, m_ph);
      chk("m_pll_rst", pll_rst, m_ph == 0);
      chk("m_sys_rst", sys_rst, m_ph != 3);
      chk("m_ready", ready, m_rdy);
      chk("m_timeout_cnt", timeout_cnt, m_tc);
      chk("m_loss_cnt", loss_cnt, m_lc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, j, bad, tc0, d;
    bit seen2, saw;
    rst = 1'b1; pll_locked = 1'b0;
    cyc(3);
    // Reset then clean lock
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_tc", timeout_cnt, 0);
    chk("rst_lc", loss_cnt, 0);
    rst = 1'b0;
    n = 1;
    for (int i = 1; i <= 6; i++) begin @(negedge clk); n += pll_rst; end
    pll_locked = 1'b1;
    j = 0;
    while (sys_rst && j < 40) begin @(negedge clk); j++; n += pll_rst; end
    chk("lock_latency", j - 1, S + 2);
    chk("pll_rst_width", n, R);
    chk("ready_first", ready, 1);
    @(negedge clk);
    chk("ready_once", ready, 0);
    chk("run_state", state, 3);
    chk("run_tc", timeout_cnt, 0);
    chk("run_lc", loss_cnt, 0);

    // Lock loss in RUN
    cyc(3);
    pll_locked = 1'b0;
    cyc(2);
    chk("sys_rst_pre_loss", sys_rst, 0);
    cyc(1);
    chk("sys_rst_after_loss", sys_rst, 1);
    chk("loss_cnt_one", loss_cnt, 1);
    pll_locked = 1'b1;
`ifdef PLL_LOCK_RESEQ_AUTO_RECOVER_EN
    chk("loss_pll_rst", pll_rst, 1);
    n = 1;
    repeat (8) begin @(negedge clk); n += pll_rst; end
    chk("loss_pll_rst_width", n, R);
`else
    chk("loss_pll_rst", pll_rst, 0);
    chk("loss_state", state, 1);
`endif
    j = 0;
    while (sys_rst && j < 100) begin @(negedge clk); j++; end
    chk("relock", sys_rst, 0);

    // Lock timeout
    rst = 1'b1; pll_locked = 1'b0;
    cyc(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (sys_rst !== 1'b1) bad++;
      if (i == 3)  chk("to_state_3", state, 0);
      if (i == 4)  chk("to_state_4", state, 1);
      if (i == 24) chk("to_state_24", state, 0);
      if (i == 28) chk("to_state_28", state, 1);
      if (i == 47) chk("to_tc_47", timeout_cnt, 1);
      if (i == 48) chk("to_tc_48", timeout_cnt, 2);
    end
    chk("to_sys_rst_held", bad, 0);

    // Lock chatter in SETTLE
    tc0 = int'(timeout_cnt);
    pll_locked = 1'b1;
    cyc(5);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    j = 0; seen2 = 0; saw = 0;
    while (sys_rst && j < 40) begin
      @(negedge clk); j++;
      if (state == 2'd2) seen2 = 1;
      if (state == 2'd1 && seen2) saw = 1;
    end
    chk("chatter_rewait", saw, 1);
    chk("chatter_latency", j - 1, S + 2);
    chk("chatter_tc", timeout_cnt, tc0);

    // Saturation and mid-run reset
    rst = 1'b1; pll_locked = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(5 * (R + T) + 5);
    chk("sat_tc", timeout_cnt, 3);
    pll_locked = 1'b1;
    j = 0;
    while (state != 2'd2 && j < 60) begin @(negedge clk); j++; end
    chk("reach_settle", state, 2);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_pll_rst", pll_rst, 1);
    chk("mid_rst_sys_rst", sys_rst, 1);
    chk("mid_rst_tc", timeout_cnt, 0);
    chk("mid_rst_lc", loss_cnt, 0);
    rst = 1'b0;

    // Random lock behaviour, biased toward holding lock long enough to reach RUN
    repeat (150) begin
      pll_locked = ($urandom_range(0, 2) != 0);
      d = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 30);
      if ($urandom_range(0, 39) == 0) begin rst = 1'b1; cyc(1); rst = 1'b0; end
      cyc(d);
    end
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
